// File: rtl/snake_pkg.sv
// Shared constants, types and helpers for the snake input path.
package snake_pkg;

  localparam int unsigned DIR_W  = 2;
  localparam int unsigned BYTE_W = 8;

  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b00;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_UP    = 2'b10;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

  localparam logic [BYTE_W-1:0] KEY_ESC   = 8'h1B;
  localparam logic [BYTE_W-1:0] KEY_LBRKT = 8'h5B;
  localparam logic [BYTE_W-1:0] KEY_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_ESC  = 2'd1,
    ST_GOT_BRKT = 2'd2
  } parse_state_e;

  typedef struct packed {
    logic             valid;
    logic [DIR_W-1:0] dir;
  } dir_cmd_t;

  // Opposite directions share bit 1 and differ in bit 0.
  function automatic logic is_reverse(input logic [DIR_W-1:0] a, input logic [DIR_W-1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  // WASD letter (either case) to direction.
  function automatic dir_cmd_t wasd_to_cmd(input logic [BYTE_W-1:0] b);
    dir_cmd_t c;
    c.valid = 1'b1;
    c.dir   = DIR_RIGHT;
    case (b)
      8'h77, 8'h57: c.dir = DIR_UP;
      8'h61, 8'h41: c.dir = DIR_LEFT;
      8'h73, 8'h53: c.dir = DIR_DOWN;
      8'h64, 8'h44: c.dir = DIR_RIGHT;
      default:      c.valid = 1'b0;
    endcase
    return c;
  endfunction

  // Final byte of an ANSI arrow sequence to direction.
  function automatic dir_cmd_t arrow_to_cmd(input logic [BYTE_W-1:0] b);
    dir_cmd_t c;
    c.valid = 1'b1;
    c.dir   = DIR_RIGHT;
    case (b)
      8'h41:   c.dir = DIR_UP;
      8'h42:   c.dir = DIR_DOWN;
      8'h43:   c.dir = DIR_RIGHT;
      8'h44:   c.dir = DIR_LEFT;
      default: c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_key_decoder_if.sv
// Byte-in / turn-out handshake bundle of the key decoder.
interface snake_key_decoder_if;
  import snake_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic [DIR_W-1:0]  cur_dir;
  logic              dir_valid;
  logic [DIR_W-1:0]  dir;
  logic              dir_ready;
  logic              paused;
  logic              seq_err;

  modport master (
    output rx_valid, rx_data, cur_dir, dir_ready,
    input  dir_valid, dir, paused, seq_err
  );

  modport slave (
    input  rx_valid, rx_data, cur_dir, dir_ready,
    output dir_valid, dir, paused, seq_err
  );

endinterface

// File: rtl/snake_dir_fifo.sv
// Small first-word-fall-through queue of 2-bit commands with registered flags/head.
module snake_dir_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [DIR_W-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [DIR_W-1:0] head,
  output logic [DIR_W-1:0] tail_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DIR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, rd_n, wr_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             do_push, do_pop;
  logic [DIR_W-1:0] head_n;

  // Next pointers/count; push into a full queue only when the head leaves the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_n    = rd_q;
    wr_n    = wr_q;
    cnt_n   = cnt_q;
    if (do_pop)  rd_n = rd_q + AW'(1);
    if (do_push) wr_n = wr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_n = cnt_q + CW'(1);
      2'b01:   cnt_n = cnt_q - CW'(1);
      default: cnt_n = cnt_q;
    endcase
    head_n = (do_push && (rd_n == wr_q)) ? push_data : mem_q[rd_n];
    tail_c = mem_q[wr_q - AW'(1)];
  end

  // Storage, pointers and registered status/head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      head  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_n;
      wr_q  <= wr_n;
      cnt_q <= cnt_n;
      full  <= (cnt_n == CW'(DEPTH));
      empty <= (cnt_n == '0);
      head  <= head_n;
      if (do_push) mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/snake_key_decoder.sv
// UART byte stream to validated snake turn commands, with pause toggle.
module snake_key_decoder
  import snake_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 25000000,
  parameter int unsigned ESC_TIMEOUT_US = 2000,
  parameter int unsigned DEPTH          = 2
) (
  input logic          clk,
  input logic          rstn,
  snake_key_decoder_if.slave bus
);

  localparam longint unsigned TO_CYC_L = (64'(ESC_TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned     TO_CYC   = (TO_CYC_L < 64'd1) ? 1 : 32'(TO_CYC_L);
  localparam int unsigned     CNT_W    = $clog2(TO_CYC + 1);

  parse_state_e     state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             cand_vld_q, cand_vld_n;
  logic [DIR_W-1:0] cand_q, cand_n;
  logic             paused_q, paused_n;
  logic             seq_err_q, seq_err_n;
  dir_cmd_t         key_cmd, arrow_cmd;

  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [DIR_W-1:0] fifo_head, fifo_tail_c, ref_dir;

  // Parser state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cand_vld_q <= 1'b0;
      cand_q     <= '0;
      paused_q   <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      cand_vld_q <= cand_vld_n;
      cand_q     <= cand_n;
      paused_q   <= paused_n;
      seq_err_q  <= seq_err_n;
    end
  end

  // Parser next state: WASD/space in IDLE, ESC '[' X sequences with inter-byte timeout.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    cand_vld_n = 1'b0;
    cand_n     = cand_q;
    paused_n   = paused_q;
    seq_err_n  = 1'b0;
    key_cmd    = wasd_to_cmd(bus.rx_data);
    arrow_cmd  = arrow_to_cmd(bus.rx_data);
    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        if (bus.rx_valid) begin
          if (bus.rx_data == KEY_ESC) begin
            state_n = ST_GOT_ESC;
          end else if (bus.rx_data == KEY_SPACE) begin
            paused_n = !paused_q;
          end else if (key_cmd.valid) begin
            cand_vld_n = 1'b1;
            cand_n     = key_cmd.dir;
          end
        end
      end
      ST_GOT_ESC, ST_GOT_BRKT: begin
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (bus.rx_data == KEY_ESC) begin
            state_n = ST_GOT_ESC;
          end else if ((state_q == ST_GOT_ESC) && (bus.rx_data == KEY_LBRKT)) begin
            state_n = ST_GOT_BRKT;
          end else if ((state_q == ST_GOT_BRKT) && arrow_cmd.valid) begin
            state_n    = ST_IDLE;
            cand_vld_n = 1'b1;
            cand_n     = arrow_cmd.dir;
          end else begin
            state_n   = ST_IDLE;
            seq_err_n = 1'b1;
          end
        end else if (cnt_q >= CNT_W'(TO_CYC - 1)) begin
          state_n   = ST_IDLE;
          cnt_n     = '0;
          seq_err_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Turn filter against the newest queued turn (or the live head direction when empty).
  always_comb begin
    ref_dir = fifo_empty ? bus.cur_dir : fifo_tail_c;
    pop     = bus.dir_ready && !fifo_empty;
    push    = cand_vld_q && !paused_q && (cand_q != ref_dir) &&
              !is_reverse(cand_q, ref_dir) && (!fifo_full || pop);
  end

  snake_dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (cand_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .tail_c    (fifo_tail_c)
  );

  assign bus.dir_valid = !fifo_empty;
  assign bus.dir       = fifo_head;
  assign bus.paused    = paused_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_snake_key_decoder.sv
// Bench for snake_key_decoder: directed vector table, hand sequences, random vs model.
module tb_snake_key_decoder;
  import snake_pkg::*;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned TO_US  = 16;
  localparam int unsigned DEPTH  = 2;
  localparam int          TO_CYC = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  snake_key_decoder_if bus();

  snake_key_decoder #(.CLK_HZ(CLK_HZ), .ESC_TIMEOUT_US(TO_US), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued turns, pending escape bytes, idle gap, pause, candidate.
  logic [1:0] mq[$];
  logic [7:0] esc[$];
  int         gap;
  bit         m_paused, m_err, m_cand_v;
  logic [1:0] m_cand;
  logic [1:0] arrow_lut [4] = '{2'b10, 2'b11, 2'b00, 2'b01};

  function automatic void model_edge(bit rst, bit v, logic [7:0] d, logic [1:0] cd, bit rdy);
    logic [1:0] rf;
    logic [7:0] lc;
    bit pop, acc;
    if (rst) begin
      mq.delete(); esc.delete();
      gap = 0; m_paused = 0; m_err = 0; m_cand_v = 0; m_cand = 2'b00;
      return;
    end
    pop = rdy && (mq.size() > 0);
    acc = 0;
    if (m_cand_v) begin
      rf  = (mq.size() > 0) ? mq[$] : cd;
      acc = (m_cand != rf) && ((m_cand ^ rf) != 2'b01) && !m_paused &&
            ((mq.size() < int'(DEPTH)) || pop);
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(m_cand);
    m_cand_v = 0;
    m_err    = 0;
    if (v) begin
      gap = 0;
      if (d == 8'h1B) begin
        esc.delete();
        esc.push_back(d);
      end else if (esc.size() == 0) begin
        if (d == 8'h20) m_paused = !m_paused;
        else begin
          lc = d | 8'h20;
          case (lc)
            8'h77: begin m_cand = 2'b10; m_cand_v = 1; end
            8'h61: begin m_cand = 2'b01; m_cand_v = 1; end
            8'h73: begin m_cand = 2'b11; m_cand_v = 1; end
            8'h64: begin m_cand = 2'b00; m_cand_v = 1; end
            default: ;
          endcase
        end
      end else if (esc.size() == 1) begin
        if (d == 8'h5B) esc.push_back(d);
        else begin esc.delete(); m_err = 1; end
      end else begin
        if (d >= 8'h41 && d <= 8'h44) begin
          m_cand   = arrow_lut[2'(d - 8'h41)];
          m_cand_v = 1;
        end else m_err = 1;
        esc.delete();
      end
    end else if (esc.size() > 0) begin
      gap++;
      if (gap >= TO_CYC) begin esc.delete(); m_err = 1; gap = 0; end
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive after negedge, model follows the edge, outputs settle 1 time unit later.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input logic [1:0] cd,
                      input bit rdy);
    @(negedge clk);
    rstn          = !rst;
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.cur_dir   = cd;
    bus.dir_ready = rdy;
    @(posedge clk);
    model_edge(rst, v, d, cd, rdy);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " valid"}, 8'(bus.dir_valid), 8'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, " dir"}, 8'(bus.dir), 8'(mq[0]));
    chk({tag, " paused"}, 8'(bus.paused), 8'(m_paused));
    chk({tag, " seq_err"}, 8'(bus.seq_err), 8'(m_err));
  endtask

  typedef struct {
    bit rst; bit v; logic [7:0] d; logic [1:0] cd; bit rdy;
    bit ev; logic [1:0] ed; bit ep; bit ee;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit v, logic [7:0] d, logic [1:0] cd, bit rdy,
                              bit ev, logic [1:0] ed, bit ep, bit ee);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.cd = cd; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.ep = ep; t.ee = ee;
    tbl.push_back(t);
  endfunction

  logic [7:0] pool [16] = '{8'h1B, 8'h5B, 8'h41, 8'h42, 8'h43, 8'h44, 8'h77, 8'h61,
                            8'h73, 8'h64, 8'h57, 8'h1B, 8'h53, 8'h5B, 8'h20, 8'h00};

  initial begin
    int pulses;
    int quiet;
    logic [1:0] cd;

    rstn = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.cur_dir = 2'b00; bus.dir_ready = 1'b0;
    model_edge(1, 0, 8'h00, 2'b00, 0);

    // Reset state
    step(1, 0, 8'h00, 2'b00, 0);
    chk("rst dir_valid", 8'(bus.dir_valid), 8'd0);
    chk("rst dir", 8'(bus.dir), 8'd0);
    chk("rst paused", 8'(bus.paused), 8'd0);
    chk("rst seq_err", 8'(bus.seq_err), 8'd0);

    // WASD filtering: reverse rejected, left legal behind queued up
    add(1,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h61,2'b00,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h77,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h61,2'b00,0, 1,2'b10,0,0);
    add(0,0,8'h00,2'b00,0, 1,2'b10,0,0);
    add(0,0,8'h00,2'b00,1, 1,2'b01,0,0);
    add(0,0,8'h00,2'b00,1, 0,2'b00,0,0);
    // ESC restart: ESC ESC [ B -> down, no error
    add(1,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h1B,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h1B,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h5B,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h42,2'b00,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b00,0, 1,2'b11,0,0);
    add(0,0,8'h00,2'b00,1, 0,2'b00,0,0);
    // Pause blocks an otherwise legal arrow; second space resumes
    add(1,0,8'h00,2'b10,0, 0,2'b00,0,0);
    add(0,1,8'h20,2'b10,0, 0,2'b00,1,0);
    add(0,1,8'h1B,2'b10,0, 0,2'b00,1,0);
    add(0,1,8'h5B,2'b10,0, 0,2'b00,1,0);
    add(0,1,8'h43,2'b10,0, 0,2'b00,1,0);
    add(0,0,8'h00,2'b10,0, 0,2'b00,1,0);
    add(0,1,8'h20,2'b10,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b10,0, 0,2'b00,0,0);
    // Full FIFO drop, then push+pop while full keeps order
    add(1,0,8'h00,2'b01,0, 0,2'b00,0,0);
    add(0,1,8'h77,2'b01,0, 0,2'b00,0,0);
    add(0,1,8'h64,2'b01,0, 1,2'b10,0,0);
    add(0,1,8'h73,2'b01,0, 1,2'b10,0,0);
    add(0,0,8'h00,2'b01,0, 1,2'b10,0,0);
    add(0,1,8'h77,2'b01,0, 1,2'b10,0,0);
    add(0,0,8'h00,2'b01,1, 1,2'b00,0,0);
    add(0,0,8'h00,2'b01,1, 1,2'b10,0,0);
    add(0,0,8'h00,2'b01,1, 0,2'b00,0,0);
    // Reset mid-sequence clears queue and pause; lone 'C' ignored
    add(1,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h77,2'b00,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b00,0, 1,2'b10,0,0);
    add(0,1,8'h20,2'b00,0, 1,2'b10,1,0);
    add(0,1,8'h1B,2'b00,0, 1,2'b10,1,0);
    add(0,1,8'h5B,2'b00,0, 1,2'b10,1,0);
    add(1,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,1,8'h43,2'b00,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b00,0, 0,2'b00,0,0);
    add(0,0,8'h00,2'b00,0, 0,2'b00,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].cd, tbl[i].rdy);
      chk($sformatf("tbl[%0d] dir_valid", i), 8'(bus.dir_valid), 8'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl[%0d] dir", i), 8'(bus.dir), 8'(tbl[i].ed));
      chk($sformatf("tbl[%0d] paused", i), 8'(bus.paused), 8'(tbl[i].ep));
      chk($sformatf("tbl[%0d] seq_err", i), 8'(bus.seq_err), 8'(tbl[i].ee));
    end

    // Spaced arrow-up: two-cycle latency, pop clears valid
    step(1, 0, 8'h00, 2'b00, 0);
    pulses = 0;
    step(0, 1, 8'h1B, 2'b00, 0);
    for (int k = 0; k < 9; k++) begin step(0, 0, 8'h00, 2'b00, 0); pulses += int'(bus.seq_err); end
    step(0, 1, 8'h5B, 2'b00, 0);
    for (int k = 0; k < 9; k++) begin step(0, 0, 8'h00, 2'b00, 0); pulses += int'(bus.seq_err); end
    step(0, 1, 8'h41, 2'b00, 0);
    chk("arrow latency1 valid", 8'(bus.dir_valid), 8'd0);
    step(0, 0, 8'h00, 2'b00, 0);
    chk("arrow latency2 valid", 8'(bus.dir_valid), 8'd1);
    chk("arrow latency2 dir", 8'(bus.dir), 8'h2);
    step(0, 0, 8'h00, 2'b00, 1);
    chk("arrow popped valid", 8'(bus.dir_valid), 8'd0);
    chk("arrow no seq_err", 8'(pulses), 8'd0);

    // Escape timeout: exactly one pulse on the TO_CYC-th idle cycle
    pulses = 0;
    step(0, 1, 8'h1B, 2'b00, 0);
    for (int k = 1; k <= TO_CYC + 2; k++) begin
      step(0, 0, 8'h00, 2'b00, 0);
      chk($sformatf("timeout cyc%0d seq_err", k), 8'(bus.seq_err), 8'(k == TO_CYC));
      pulses += int'(bus.seq_err);
    end
    chk("timeout pulse count", 8'(pulses), 8'd1);
    step(0, 1, 8'h41, 2'b00, 0);
    step(0, 0, 8'h00, 2'b00, 0);
    chk("after timeout 'A' valid", 8'(bus.dir_valid), 8'd0);
    step(0, 0, 8'h00, 2'b00, 0);

    // Bytes arriving one cycle before the timeout keep the sequence alive
    pulses = 0;
    step(0, 1, 8'h1B, 2'b00, 0);
    for (int k = 0; k < TO_CYC - 1; k++) begin step(0, 0, 8'h00, 2'b00, 0); pulses += int'(bus.seq_err); end
    step(0, 1, 8'h5B, 2'b00, 0);
    for (int k = 0; k < TO_CYC - 1; k++) begin step(0, 0, 8'h00, 2'b00, 0); pulses += int'(bus.seq_err); end
    step(0, 1, 8'h41, 2'b00, 0);
    step(0, 0, 8'h00, 2'b00, 0);
    chk("late arrow valid", 8'(bus.dir_valid), 8'd1);
    chk("late arrow dir", 8'(bus.dir), 8'h2);
    chk("late arrow seq_err count", 8'(pulses), 8'd0);
    step(0, 0, 8'h00, 2'b00, 1);

    // Random traffic against the model
    step(1, 0, 8'h00, 2'b00, 0);
    quiet = 0;
    cd = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      bit r, v, rdy;
      int idx;
      logic [7:0] d;
      r = ($urandom_range(0, 499) == 0);
      if (quiet > 0) begin
        v = 0;
        quiet--;
      end else begin
        v = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(TO_CYC - 2, TO_CYC + 2);
      end
      idx = $urandom_range(0, 15);
      d = (idx == 15) ? 8'($urandom) : pool[idx];
      if ($urandom_range(0, 7) == 0) cd = 2'($urandom);
      rdy = ($urandom_range(0, 2) == 0);
      step(r, v, d, cd, rdy);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
